// File: rtl/board_tracker.sv
// board_tracker: 3x3 tic-tac-toe board datapath.
// Records accepted moves, flags illegal moves in the same cycle, registers
// win/winner/no_space, and freezes the board once the game is over.
module board_tracker #(
  parameter int CELLS = 9,
  parameter int PW    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 player1_play,
  input  logic                 player2_play,
  input  logic [PW-1:0]        pos1,
  input  logic [PW-1:0]        pos2,
  output logic                 illegal,
  output logic                 no_space,
  output logic                 win,
  output logic [1:0]           winner,
  output logic [2*CELLS-1:0]   board,
  output logic [3:0]           move_count,
  output logic                 collision
);

  typedef enum logic {S_PLAYING, S_DONE} state_t;

  state_t               r_state;
  logic [2*CELLS-1:0]   r_board;
  logic [3:0]           r_count;
  logic                 r_win;
  logic [1:0]           r_winner;
  logic                 r_full;
  logic                 r_collision;

  logic                 w_active;
  logic [PW-1:0]        w_pos;
  logic [1:0]           w_mark;
  logic                 w_pos_ok;
  logic [1:0]           w_cell;
  logic                 w_illegal;
  logic                 w_accept;
  logic [2*CELLS-1:0]   w_next_board;
  logic [3:0]           w_next_count;
  logic                 w_line;

  // True when mark m occupies all three cells of any row, column or diagonal.
  function automatic logic line_win(input logic [2*CELLS-1:0] b, input logic [1:0] m);
    logic [1:0] c [0:8];
    for (int k = 0; k < 9; k++) c[k] = b[2*k +: 2];
    line_win = ((c[0] == m) && (c[1] == m) && (c[2] == m)) ||
               ((c[3] == m) && (c[4] == m) && (c[5] == m)) ||
               ((c[6] == m) && (c[7] == m) && (c[8] == m)) ||
               ((c[0] == m) && (c[3] == m) && (c[6] == m)) ||
               ((c[1] == m) && (c[4] == m) && (c[7] == m)) ||
               ((c[2] == m) && (c[5] == m) && (c[8] == m)) ||
               ((c[0] == m) && (c[4] == m) && (c[8] == m)) ||
               ((c[2] == m) && (c[4] == m) && (c[6] == m));
  endfunction

  // Select the active move (player 1 wins ties), check legality, build next board.
  always_comb begin
    w_active     = player1_play | player2_play;
    w_pos        = player1_play ? pos1 : pos2;
    w_mark       = player1_play ? 2'b01 : 2'b10;
    w_pos_ok     = (w_pos != '0) && (w_pos <= PW'(CELLS));
    w_cell       = 2'b00;
    w_next_board = r_board;
    for (int k = 0; k < CELLS; k++) begin
      if (w_pos == PW'(k + 1)) w_cell = r_board[2*k +: 2];
    end
    w_illegal    = w_active && (!w_pos_ok || (w_cell != 2'b00) || (r_state == S_DONE));
    w_accept     = w_active && !w_illegal;
    for (int k = 0; k < CELLS; k++) begin
      if (w_accept && (w_pos == PW'(k + 1))) w_next_board[2*k +: 2] = w_mark;
    end
    w_next_count = r_count + 4'd1;
    w_line       = line_win(w_next_board, w_mark);
  end

  // Game state: record accepted moves, latch win/full, lock the board when done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_PLAYING;
      r_board     <= '0;
      r_count     <= '0;
      r_win       <= 1'b0;
      r_winner    <= 2'b00;
      r_full      <= 1'b0;
      r_collision <= 1'b0;
    end else if (clear) begin
      r_state     <= S_PLAYING;
      r_board     <= '0;
      r_count     <= '0;
      r_win       <= 1'b0;
      r_winner    <= 2'b00;
      r_full      <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      if (player1_play && player2_play) r_collision <= 1'b1;
      if (w_accept) begin
        r_board  <= w_next_board;
        r_count  <= w_next_count;
        r_win    <= w_line;
        r_winner <= w_line ? w_mark : 2'b00;
        r_full   <= (w_next_count == 4'(CELLS));
        r_state  <= (w_line || (w_next_count == 4'(CELLS))) ? S_DONE : S_PLAYING;
      end
    end
  end

  assign illegal    = w_illegal;
  assign board      = r_board;
  assign move_count = r_count;
  assign win        = r_win;
  assign winner     = r_winner;
  assign no_space   = r_full;
  assign collision  = r_collision;

endmodule

// File: tb/tb_board_tracker.sv
// Directed testbench for board_tracker.
module tb_board_tracker;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        player1_play = 1'b0;
  logic        player2_play = 1'b0;
  logic [3:0]  pos1 = 4'd0;
  logic [3:0]  pos2 = 4'd0;
  logic        illegal;
  logic        no_space;
  logic        win;
  logic [1:0]  winner;
  logic [17:0] board;
  logic [3:0]  move_count;
  logic        collision;

  int errors = 0;
  int checks = 0;

  board_tracker #(.CELLS(9), .PW(4)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .player1_play(player1_play), .player2_play(player2_play),
    .pos1(pos1), .pos2(pos2),
    .illegal(illegal), .no_space(no_space), .win(win), .winner(winner),
    .board(board), .move_count(move_count), .collision(collision)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one strobe cycle, check illegal in that cycle, then step past the edge.
  task automatic play(input logic p1, input logic p2, input logic [3:0] a,
                      input logic [3:0] b, input logic exp_ill, input string tag);
    player1_play = p1; player2_play = p2; pos1 = a; pos2 = b;
    #1;
    check({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
    @(posedge clock); #1;
    player1_play = 1'b0; player2_play = 1'b0; pos1 = 4'd0; pos2 = 4'd0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  initial begin
    // Reset held low: all outputs at reset values, illegal evaluates on empty board.
    #3;
    check("rst_board", 32'(board), 32'h0);
    check("rst_count", 32'(move_count), 32'd0);
    check("rst_win", 32'(win), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_nospace", 32'(no_space), 32'd0);
    check("rst_coll", 32'(collision), 32'd0);
    player1_play = 1'b1; pos1 = 4'd5; #1;
    check("rst_illegal", 32'(illegal), 32'd0);
    player1_play = 1'b0; pos1 = 4'd0;
    #4 reset = 1'b1;
    @(posedge clock); #1;

    // First move and illegal cases.
    play(1, 0, 4'd5, 4'd0, 1'b0, "p1_5");
    check("m1_board", 32'(board), 32'h100);
    check("m1_count", 32'(move_count), 32'd1);
    check("m1_win", 32'(win), 32'd0);
    play(0, 1, 4'd0, 4'd5, 1'b1, "p2_occupied");
    play(1, 0, 4'd0, 4'd0, 1'b1, "p1_pos0");
    play(1, 0, 4'd12, 4'd0, 1'b1, "p1_pos12");
    check("ill_board", 32'(board), 32'h100);
    check("ill_count", 32'(move_count), 32'd1);
    do_clear();
    check("clr_board", 32'(board), 32'h0);

    // Top-row win for player 1.
    play(1, 0, 4'd1, 4'd0, 1'b0, "rw1");
    play(0, 1, 4'd0, 4'd4, 1'b0, "rw2");
    play(1, 0, 4'd2, 4'd0, 1'b0, "rw3");
    play(0, 1, 4'd0, 4'd5, 1'b0, "rw4");
    check("rw_prewin", 32'(win), 32'd0);
    play(1, 0, 4'd3, 4'd0, 1'b0, "rw5");
    check("rw_win", 32'(win), 32'd1);
    check("rw_winner", 32'(winner), 32'd1);
    check("rw_count", 32'(move_count), 32'd5);
    check("rw_nospace", 32'(no_space), 32'd0);
    check("rw_board", 32'(board), 32'h295);
    play(0, 1, 4'd0, 4'd9, 1'b1, "done_p2_9");
    check("done_board", 32'(board), 32'h295);
    check("done_count", 32'(move_count), 32'd5);
    do_clear();

    // Full-board draw: X O X / X O O / O X X.
    play(1, 0, 4'd1, 4'd0, 1'b0, "dr1");
    play(0, 1, 4'd0, 4'd2, 1'b0, "dr2");
    play(1, 0, 4'd3, 4'd0, 1'b0, "dr3");
    play(0, 1, 4'd0, 4'd5, 1'b0, "dr4");
    play(1, 0, 4'd4, 4'd0, 1'b0, "dr5");
    play(0, 1, 4'd0, 4'd6, 1'b0, "dr6");
    play(1, 0, 4'd8, 4'd0, 1'b0, "dr7");
    play(0, 1, 4'd0, 4'd7, 1'b0, "dr8");
    check("dr8_nospace", 32'(no_space), 32'd0);
    play(1, 0, 4'd9, 4'd0, 1'b0, "dr9");
    check("dr_nospace", 32'(no_space), 32'd1);
    check("dr_win", 32'(win), 32'd0);
    check("dr_winner", 32'(winner), 32'd0);
    check("dr_count", 32'(move_count), 32'd9);
    check("dr_board", 32'(board), 32'h16A59);
    play(0, 1, 4'd0, 4'd1, 1'b1, "dr_after");
    check("dr_after_count", 32'(move_count), 32'd9);
    do_clear();

    // Ninth move completes the 1-5-9 diagonal.
    play(1, 0, 4'd1, 4'd0, 1'b0, "wf1");
    play(0, 1, 4'd0, 4'd2, 1'b0, "wf2");
    play(1, 0, 4'd3, 4'd0, 1'b0, "wf3");
    play(0, 1, 4'd0, 4'd4, 1'b0, "wf4");
    play(1, 0, 4'd5, 4'd0, 1'b0, "wf5");
    play(0, 1, 4'd0, 4'd6, 1'b0, "wf6");
    play(1, 0, 4'd8, 4'd0, 1'b0, "wf7");
    play(0, 1, 4'd0, 4'd7, 1'b0, "wf8");
    check("wf8_win", 32'(win), 32'd0);
    play(1, 0, 4'd9, 4'd0, 1'b0, "wf9");
    check("wf_win", 32'(win), 32'd1);
    check("wf_nospace", 32'(no_space), 32'd1);
    check("wf_winner", 32'(winner), 32'd1);
    check("wf_board", 32'(board), 32'h16999);
    do_clear();

    // Simultaneous strobes: player 1 wins, collision is sticky.
    play(1, 1, 4'd2, 4'd3, 1'b0, "coll");
    check("coll_board", 32'(board), 32'h4);
    check("coll_flag", 32'(collision), 32'd1);
    check("coll_count", 32'(move_count), 32'd1);
    play(0, 1, 4'd0, 4'd3, 1'b0, "coll_p2");
    check("coll_sticky", 32'(collision), 32'd1);
    check("coll_board2", 32'(board), 32'h24);
    // Clear beats a strobe in the same cycle.
    clear = 1'b1; player1_play = 1'b1; pos1 = 4'd7;
    @(posedge clock); #1;
    clear = 1'b0; player1_play = 1'b0; pos1 = 4'd0;
    check("clrmv_board", 32'(board), 32'h0);
    check("clrmv_count", 32'(move_count), 32'd0);
    check("clrmv_coll", 32'(collision), 32'd0);

    // Asynchronous reset between edges.
    play(1, 0, 4'd5, 4'd0, 1'b0, "ar1");
    play(0, 1, 4'd0, 4'd1, 1'b0, "ar2");
    check("ar_pre_board", 32'(board), 32'h102);
    #2 reset = 1'b0;
    #1;
    check("ar_board", 32'(board), 32'h0);
    check("ar_count", 32'(move_count), 32'd0);
    check("ar_win", 32'(win), 32'd0);
    check("ar_nospace", 32'(no_space), 32'd0);
    player2_play = 1'b1; pos2 = 4'd5; #1;
    check("ar_illegal", 32'(illegal), 32'd0);
    player2_play = 1'b0; pos2 = 4'd0;
    #1 reset = 1'b1;
    @(posedge clock); #1;
    play(1, 0, 4'd5, 4'd0, 1'b0, "ar_after");
    check("ar_after_board", 32'(board), 32'h100);
    check("ar_after_count", 32'(move_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/board_tracker.md
Name: board_tracker

Overview:
- Game-board datapath feeding the tic-tac-toe turn controller.
- Stores the 3x3 board and records each move when the controller asserts player1_play or player2_play.
- Produces the controller's decision inputs: illegal (combinational, same cycle), win and no_space (registered).
- Locks the board once the game ends, until clear or reset.

Parameters:
- CELLS, 9, number of board cells; fixed 3x3 layout, not meant to be overridden.
- PW, 4, width of position inputs; legal positions are 1..9.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces every register to its reset value.
- clear  input  1  synchronous new-game clear; active high.
- player1_play  input  1  write strobe for player 1; one move per cycle asserted.
- player2_play  input  1  write strobe for player 2.
- pos1  input  PW  cell index for a player 1 move.
- pos2  input  PW  cell index for a player 2 move.
- illegal  output  1  combinational; active move is invalid.
- no_space  output  1  registered; all 9 cells occupied.
- win  output  1  registered; a line of three is complete.
- winner  output  2  registered; 01 = player 1, 10 = player 2, 00 = none.
- board  output  18  registered board; cell k (1..9) is bits [2k-1:2k-2]. Encoding: 00 empty, 01 P1, 10 P2.
- move_count  output  4  registered count of accepted moves, 0..9.
- collision  output  1  registered sticky flag; both strobes were seen in the same cycle.

Behaviour:
- Reset values (reset = 0, immediate): board = 0, move_count = 0, win = 0, winner = 00, no_space = 0, collision = 0. Internal state = PLAYING.
- Cell indexing: pos = 1..9 maps row-major (1 = top-left, 9 = bottom-right). pos = 0 or pos >= 10 is invalid.
- Active move selection:
  - player1_play = 1: active pos is pos1, mark is 01.
  - player2_play = 1 and player1_play = 0: active pos is pos2, mark is 10.
  - No strobe: no active move.
- illegal (purely combinational, from the registered board and current inputs) = active move exists AND any of:
  - position invalid;
  - target cell non-zero;
  - state = DONE.
  - Otherwise illegal = 0. It must be valid in the same cycle as the strobe, because the controller samples it in that cycle.
- Move acceptance: an active move with illegal = 0 writes the mark into the cell at the next rising edge and increments move_count by 1. Illegal moves change no state.
- Simultaneous strobes: player 1 has priority and the player 2 move is dropped. collision is set at that edge and stays set until clear or reset.
- Win detection: evaluated combinationally on the next-board value (8 lines: 3 rows, 3 columns, 2 diagonals). win and winner register at the same edge as the winning write.
  - win rises in the cycle after the strobe, together with the updated board.
  - Only the mover can complete a line, so winner equals the mover's mark.
- no_space: registered, = (next move_count == 9). Rises together with the 9th write.
  - If the 9th move also wins: win = 1 and no_space = 1 in the same cycle, and winner is valid.
- State machine:
  - PLAYING -> DONE at the edge where the next-board value has win = 1 or move_count reaches 9.
  - DONE holds the board, win, winner, no_space and move_count frozen. Any strobe in DONE raises illegal and changes nothing.
  - DONE -> PLAYING only on clear or reset.
- clear = 1 at an edge: all registers return to their reset values and the state returns to PLAYING. clear has priority over any strobe in the same cycle; that move is discarded.
- Reset mid-operation: asynchronous clear of everything regardless of clock. Outputs are valid reset values while reset = 0. illegal still evaluates against the cleared (all-zero) board.
- move_count never exceeds 9 and never wraps.

Test Plan:
- Reset, then P1 pos1 = 5 for one cycle -> illegal = 0 that cycle; next cycle board[9:8] = 01, move_count = 1, win = 0.
- P1 pos = 5, then P2 pos2 = 5 -> illegal = 1 during the P2 strobe; board unchanged, move_count stays 1. Also pos1 = 0 and pos1 = 12 -> illegal = 1.
- Row win: moves P1 1, P2 4, P1 2, P2 5, P1 3 -> one cycle after the last strobe, win = 1, winner = 01, move_count = 5. A later P2 strobe at pos 9 -> illegal = 1, board frozen.
- Full-board draw: X O X / X O O / O X X, played legally -> after the 9th write, no_space = 1, win = 0, winner = 00. Repeat with a 9th move that completes a line -> win = 1 and no_space = 1 together.
- player1_play and player2_play both high (pos1 = 2, pos2 = 3) -> cell 2 = 01, cell 3 empty, collision = 1 and sticky. clear in the same cycle as a strobe -> board = 0, move_count = 0, collision = 0, move discarded.
- Drop reset low between clock edges mid-game -> board, win, winner, no_space and move_count go to 0 immediately (asynchronous). After release, the first legal move is accepted normally.
